// File: rtl/lane_dispatch5.sv
// rtl/lane_dispatch5.sv - single-transaction dispatcher to NUM_LANES lanes with unicast/broadcast,
// per-lane handshakes, and drop accounting for out-of-range lane indices.
module lane_dispatch5 #(
  parameter int DATA_W    = 16,
  parameter int NUM_LANES = 5,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_lane,
  input  logic                 in_bcast,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy,
  output logic                 err_bad_lane,
  output logic [CNT_W-1:0]     drop_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 xfer;
  logic                 lane_ok;

  // Ready when every still-pending lane is handshaking now, so a completing cycle can take the next one.
  assign in_ready = (state_q == IDLE) || ((pending_q & ~out_ready) == '0);
  assign xfer     = in_valid && in_ready;
  assign lane_ok  = in_bcast || (in_lane < IDX_W'(NUM_LANES));

  always_comb begin
    pending_d = pending_q & ~out_ready;
    data_d    = data_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (xfer) begin
      if (lane_ok) begin
        data_d    = in_data;
        pending_d = in_bcast ? {NUM_LANES{1'b1}} : (NUM_LANES'(1) << in_lane);
      end else begin
        err_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
    end
    state_d = (pending_d == '0) ? IDLE : HOLD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid    = pending_q;
  assign out_data     = data_q;
  assign busy         = (state_q == HOLD);
  assign err_bad_lane = err_q;
  assign drop_count   = cnt_q;

endmodule
